// File: rtl/sra_engine.sv
// Self-sequenced magnitude approximation: out = max(x - x/8 + y/2, x) with
// x = max(|a|,|b|), y = min(|a|,|b|); six-cycle start-to-done latency.
module sra_engine #(
  parameter int WIDTH  = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   out
);

  localparam int RW = WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ABS   = 3'd1,
    S_ORDER = 3'd2,
    S_SCALE = 3'd3,
    S_SUM   = 3'd4,
    S_CMP   = 3'd5
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [RW-1:0] r1_r, r2_r, r3_r, r4_r, r5_r;
  logic [RW-1:0] r1_nxt_s, r2_nxt_s, r3_nxt_s, r4_nxt_s, r5_nxt_s;
  logic          busy_r, busy_nxt_s;
  logic          done_r, done_nxt_s;
  logic [RW-1:0] out_r, out_nxt_s;

  // The extra register bit lets |most-negative| = 2^(WIDTH-1) stay positive.
  function automatic logic [RW-1:0] extend(input logic [WIDTH-1:0] v);
    if (SIGNED) begin
      return {v[WIDTH-1], v};
    end else begin
      return {1'b0, v};
    end
  endfunction

  function automatic logic [RW-1:0] abs_val(input logic [RW-1:0] v);
    if (SIGNED && v[RW-1]) begin
      return (~v) + {{(RW-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  // Next-state, datapath and output decode for the sequencing FSM.
  always_comb begin
    state_nxt_s = state_r;
    r1_nxt_s    = r1_r;
    r2_nxt_s    = r2_r;
    r3_nxt_s    = r3_r;
    r4_nxt_s    = r4_r;
    r5_nxt_s    = r5_r;
    busy_nxt_s  = busy_r;
    done_nxt_s  = 1'b0;
    out_nxt_s   = out_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          r1_nxt_s    = extend(in1);
          r2_nxt_s    = extend(in2);
          busy_nxt_s  = 1'b1;
          state_nxt_s = S_ABS;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ABS: begin
        r1_nxt_s    = abs_val(r1_r);
        r2_nxt_s    = abs_val(r2_r);
        state_nxt_s = S_ORDER;
      end
      S_ORDER: begin
        if (r2_r > r1_r) begin
          r1_nxt_s = r2_r;
          r2_nxt_s = r1_r;
        end else begin
          r1_nxt_s = r1_r;
          r2_nxt_s = r2_r;
        end
        state_nxt_s = S_SCALE;
      end
      S_SCALE: begin
        r3_nxt_s    = r1_r - (r1_r >> 3'd3);
        r4_nxt_s    = r2_r >> 1'd1;
        state_nxt_s = S_SUM;
      end
      S_SUM: begin
        r5_nxt_s    = r3_r + r4_r;
        state_nxt_s = S_CMP;
      end
      S_CMP: begin
        if (r5_r >= r1_r) begin
          out_nxt_s = r5_r;
        end else begin
          out_nxt_s = r1_r;
        end
        done_nxt_s  = 1'b1;
        busy_nxt_s  = 1'b0;
        state_nxt_s = S_IDLE;
      end
      default: begin
        busy_nxt_s  = 1'b0;
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      r1_r    <= {RW{1'b0}};
      r2_r    <= {RW{1'b0}};
      r3_r    <= {RW{1'b0}};
      r4_r    <= {RW{1'b0}};
      r5_r    <= {RW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      out_r   <= {RW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      r1_r    <= r1_nxt_s;
      r2_r    <= r2_nxt_s;
      r3_r    <= r3_nxt_s;
      r4_r    <= r4_nxt_s;
      r5_r    <= r5_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
      out_r   <= out_nxt_s;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign out  = out_r;

endmodule

// File: doc/sra_engine.md
Name: sra_engine

Overview:
- Self-sequenced square-root approximation (SRA) engine: result ≈ sqrt(a²+b²) = max(0.875·x + 0.5·y, x), where x = max(|a|,|b|) and y = min(|a|,|b|).
- Successor to the fixed 16-bit, externally control-worded SRA datapath. Differences:
  - width is parametrised;
  - signed/unsigned operands are selectable;
  - an internal FSM sequences the datapath;
  - start/busy/done handshake;
  - output is widened so it never overflows.
- Sits between operand-producing logic and a magnitude consumer.

Parameters:
- WIDTH, 16, operand width in bits (≥4).
- SIGNED, 0, 1 = operands are two's complement and abs is taken; 0 = operands are unsigned.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- in1  in  WIDTH  operand a; captured on accepted start.
- in2  in  WIDTH  operand b; captured on accepted start.
- busy  out  1  high from the cycle after start is accepted until done is asserted.
- done  out  1  one-cycle pulse; out is valid from this cycle onward.
- out  out  WIDTH+1  unsigned result; holds until the next done.

Behaviour:
- Reset: when rst_n=0 at a clk edge: state=IDLE, busy=0, done=0, out=0, internal regs R1..R5 = 0. Reset mid-operation aborts the computation; no done is produced.
- Internal regs R1..R5 are each WIDTH+1 bits, unsigned after ABS. Shifts are logical, zero-filled. No saturation is needed: the max result is 1.375·(2^WIDTH − 1), which is < 2^(WIDTH+1).
- FSM states and transitions, one edge per state:
  - IDLE: if start=1 → R1=in1, R2=in2 (sign-extended if SIGNED, zero-extended otherwise), busy←1, → ABS. Otherwise stay.
  - ABS: if SIGNED, R1=|R1| and R2=|R2|; the most-negative value maps to 2^(WIDTH−1). If SIGNED=0, R1/R2 are unchanged. → ORDER.
  - ORDER: R1=max(R1,R2), R2=min(R1,R2). Ties leave both unchanged. → SCALE.
  - SCALE: R3=R1−(R1>>3), R4=R2>>1. → SUM.
  - SUM: R5=R3+R4. → CMP.
  - CMP: out←(R5≥R1)?R5:R1, done←1, busy←0. → IDLE.
- done clears on the next edge unless re-set.
- Latency: start sampled at edge N → done=1 and out valid in the cycle after edge N+5, i.e. 6 cycles.
- Back-to-back: start high in the done cycle is accepted at that edge (FSM is in IDLE). Throughput is 1 result per 6 cycles.
- start while busy=1: ignored. in1/in2 changes while busy have no effect.
- start held high continuously: a new operation is accepted every 6 cycles.
- out changes only at the CMP edge or at reset. It is stable between done pulses.
- Result is symmetric: (a,b) and (b,a) give identical out.

Test Plan:
1. WIDTH=16, SIGNED=0, in1=3, in2=4, start pulse → done exactly 6 cycles after the start edge, out=5. Repeat with in1=4, in2=3 → out=5.
2. WIDTH=16, SIGNED=0, in1=8, in2=0 → out=8 (x branch wins over 7). Then in1=0xFFFF, in2=0xFFFF → out=0x15FFF (90111), no overflow.
3. WIDTH=8, SIGNED=1, in1=−128 (0x80), in2=−128 → out=176. Then in1=−3, in2=4 → out=5.
4. Start asserted again at cycles 2 and 4 while busy, with changed operands → ignored; a single done with the original result. Start held high through the done cycle → second operation accepted at that edge; next done 6 cycles later.
5. rst_n=0 for one edge during SUM → next cycle busy=0, done=0, out=0. No done appears afterward. A fresh start then computes correctly.
6. Randomised operands (both SIGNED settings, WIDTH=8/16) versus a reference model of max(x−(x>>3)+(y>>1), x) → exact match. out is stable between done pulses.
